// File: rtl/preproc_pkg.sv
// Shared types and constants for the RGB565 3x3 window filter.
package preproc_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_HORZ   = 2'd1,
        MODE_GAUSS  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int RB_ACC_W = 9;
    localparam int G_ACC_W  = 10;

    localparam logic [RB_ACC_W-1:0] RB_GAUSS_RND = 9'd8;
    localparam logic [G_ACC_W-1:0]  G_GAUSS_RND  = 10'd8;
    localparam logic [RB_ACC_W-1:0] RB_HORZ_RND  = 9'd2;
    localparam logic [G_ACC_W-1:0]  G_HORZ_RND   = 10'd2;
    localparam int GAUSS_SHIFT = 4;
    localparam int HORZ_SHIFT  = 2;

    typedef struct packed {
        logic [15:0] top;
        logic [15:0] mid;
        logic [15:0] bot;
    } col_t;

    // Edge replication: a missing row is replaced by the centre row.
    function automatic col_t vclamp(col_t c, logic at_top, logic at_bot);
        col_t o;
        o = c;
        if (at_top) o.top = c.mid;
        if (at_bot) o.bot = c.mid;
        return o;
    endfunction

    function automatic int kshift(int r, int c);
        return ((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage, read-before-write at a single address.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/rgb565_window_filter.sv
// 3x3 smoothing stage for RGB565 video: bypass, [1 2 1] or Gaussian kernel.
module rgb565_window_filter
    import preproc_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pixel_in,
    input  logic        data_valid_in,
    input  logic        sof_in,
    input  logic [1:0]  mode_in,
    output logic        ready_out,
    output logic [15:0] pixel_out,
    output logic        data_valid_out,
    output logic        sof_out,
    output logic        eol_out,
    output logic        eof_out,
    output logic        frame_error_out
);

    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(TOTAL + IMG_WIDTH + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] FILL_END  = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] RUN_END   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FLUSH_END = CW'(TOTAL + IMG_WIDTH);

    state_t          r_state;
    state_t          w_next;
    mode_t           r_mode;
    logic [XW-1:0]   r_xi;
    logic [XW-1:0]   r_cx;
    logic [YW-1:0]   r_cy;
    logic [CW-1:0]   r_cnt;
    col_t            r_c1;
    col_t            r_c2;
    col_t            w_cn;
    col_t            w_lc;
    col_t            w_rc;
    col_t            w_cols [3];
    logic [15:0]     w_px [3][3];
    logic [15:0]     w_lb1_rd;
    logic [15:0]     w_lb2_rd;
    logic [XW-1:0]   w_addr;
    logic            w_acc;
    logic            w_sof_acc;
    logic            w_step;
    logic            w_emit;
    logic            w_top;
    logic            w_bot;
    logic [RB_ACC_W-1:0] w_gr;
    logic [G_ACC_W-1:0]  w_gg;
    logic [RB_ACC_W-1:0] w_gb;
    logic [RB_ACC_W-1:0] w_hr;
    logic [G_ACC_W-1:0]  w_hg;
    logic [RB_ACC_W-1:0] w_hb;
    logic [15:0]     w_result;
    logic [15:0]     r_pix;
    logic            r_dv;
    logic            r_sof;
    logic            r_eol;
    logic            r_eof;
    logic            r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_sof_acc) w_next = ST_FILL;
            end
            ST_FILL: begin
                if (w_sof_acc)                        w_next = ST_FILL;
                else if (w_acc && r_cnt == FILL_END)  w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_sof_acc)                        w_next = ST_FILL;
                else if (w_acc && r_cnt == RUN_END)   w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_cnt == FLUSH_END) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Flush cycles behave as virtual accepts so the last line drains.
    always_comb begin
        ready_out = (r_state != ST_FLUSH);
        w_acc     = data_valid_in && ready_out;
        w_sof_acc = w_acc && sof_in;
        w_step    = (w_acc && (r_state != ST_IDLE || sof_in))
                 || (r_state == ST_FLUSH);
        w_emit    = (r_state == ST_RUN && w_acc && !sof_in)
                 || (r_state == ST_FLUSH);
        w_addr    = w_sof_acc ? '0 : r_xi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xi   <= '0;
            r_cnt  <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_mode <= MODE_BYPASS;
        end else if (w_sof_acc) begin
            r_xi   <= XW'(1);
            r_cnt  <= CW'(1);
            r_cx   <= '0;
            r_cy   <= '0;
            r_mode <= mode_t'(mode_in);
        end else begin
            if (w_step) begin
                r_xi  <= (r_xi == X_LAST) ? '0 : r_xi + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_emit) begin
                if (r_cx == X_LAST) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == Y_LAST) ? '0 : r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
        end
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW), .DW(16)) u_lb1 (
        .clk     (clk),
        .i_we    (w_step),
        .i_addr  (w_addr),
        .i_wdata (pixel_in),
        .o_rdata (w_lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW), .DW(16)) u_lb2 (
        .clk     (clk),
        .i_we    (w_step),
        .i_addr  (w_addr),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb2_rd)
    );

    assign w_cn = {w_lb2_rd, w_lb1_rd, pixel_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (w_step) begin
            r_c1 <= r_c2;
            r_c2 <= w_cn;
        end
    end

    // r_c2 always holds the centre column; edges reuse it.
    always_comb begin
        w_lc      = (r_cx == '0) ? r_c2 : r_c1;
        w_rc      = (r_cx == X_LAST) ? r_c2 : w_cn;
        w_top     = (r_cy == '0);
        w_bot     = (r_cy == Y_LAST);
        w_cols[0] = vclamp(w_lc, w_top, w_bot);
        w_cols[1] = vclamp(r_c2, w_top, w_bot);
        w_cols[2] = vclamp(w_rc, w_top, w_bot);
        for (int c = 0; c < 3; c++) begin
            w_px[0][c] = w_cols[c].top;
            w_px[1][c] = w_cols[c].mid;
            w_px[2][c] = w_cols[c].bot;
        end
    end

    always_comb begin
        w_gr = '0;
        w_gg = '0;
        w_gb = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_gr = w_gr + (RB_ACC_W'(w_px[r][c][R_MSB:R_LSB]) << kshift(r, c));
                w_gg = w_gg + (G_ACC_W'(w_px[r][c][G_MSB:G_LSB]) << kshift(r, c));
                w_gb = w_gb + (RB_ACC_W'(w_px[r][c][B_MSB:B_LSB]) << kshift(r, c));
            end
        end
        w_gr = w_gr + RB_GAUSS_RND;
        w_gg = w_gg + G_GAUSS_RND;
        w_gb = w_gb + RB_GAUSS_RND;
        w_hr = RB_ACC_W'(w_px[1][0][R_MSB:R_LSB])
             + (RB_ACC_W'(w_px[1][1][R_MSB:R_LSB]) << 1)
             + RB_ACC_W'(w_px[1][2][R_MSB:R_LSB]) + RB_HORZ_RND;
        w_hg = G_ACC_W'(w_px[1][0][G_MSB:G_LSB])
             + (G_ACC_W'(w_px[1][1][G_MSB:G_LSB]) << 1)
             + G_ACC_W'(w_px[1][2][G_MSB:G_LSB]) + G_HORZ_RND;
        w_hb = RB_ACC_W'(w_px[1][0][B_MSB:B_LSB])
             + (RB_ACC_W'(w_px[1][1][B_MSB:B_LSB]) << 1)
             + RB_ACC_W'(w_px[1][2][B_MSB:B_LSB]) + RB_HORZ_RND;
    end

    always_comb begin
        unique case (r_mode)
            MODE_GAUSS: w_result = {5'(w_gr >> GAUSS_SHIFT),
                                    6'(w_gg >> GAUSS_SHIFT),
                                    5'(w_gb >> GAUSS_SHIFT)};
            MODE_HORZ:  w_result = {5'(w_hr >> HORZ_SHIFT),
                                    6'(w_hg >> HORZ_SHIFT),
                                    5'(w_hb >> HORZ_SHIFT)};
            default:    w_result = w_px[1][1];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= '0;
            r_dv  <= 1'b0;
            r_sof <= 1'b0;
            r_eol <= 1'b0;
            r_eof <= 1'b0;
        end else begin
            r_dv  <= w_emit;
            r_sof <= w_emit && r_cx == '0 && r_cy == '0;
            r_eol <= w_emit && r_cx == X_LAST;
            r_eof <= w_emit && r_cx == X_LAST && r_cy == Y_LAST;
            if (w_emit) r_pix <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((data_valid_in && !ready_out)
                  || (w_sof_acc && (r_state == ST_FILL || r_state == ST_RUN))) begin
            r_err <= 1'b1;
        end
    end

    assign pixel_out       = r_pix;
    assign data_valid_out  = r_dv;
    assign sof_out         = r_sof;
    assign eol_out         = r_eol;
    assign eof_out         = r_eof;
    assign frame_error_out = r_err;

endmodule

// File: tb/tb_rgb565_window_filter.sv
// Directed bench for rgb565_window_filter on a 4x3 image.
module tb_rgb565_window_filter;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pixel_in = '0;
    logic        data_valid_in = 1'b0;
    logic        sof_in = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic        ready_out;
    logic [15:0] pixel_out;
    logic        data_valid_out;
    logic        sof_out;
    logic        eol_out;
    logic        eof_out;
    logic        frame_error_out;

    rgb565_window_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pixel_in        (pixel_in),
        .data_valid_in   (data_valid_in),
        .sof_in          (sof_in),
        .mode_in         (mode_in),
        .ready_out       (ready_out),
        .pixel_out       (pixel_out),
        .data_valid_out  (data_valid_out),
        .sof_out         (sof_out),
        .eol_out         (eol_out),
        .eof_out         (eof_out),
        .frame_error_out (frame_error_out)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] cap_pix [32];
    time         cap_t [32];
    int          ncap = 0;
    int          nlow = 0;
    logic [31:0] sofv = '0;
    logic [31:0] eolv = '0;
    logic [31:0] eofv = '0;
    logic [15:0] frm [N];
    logic [15:0] expv [N];
    time         t6;
    time         tlast;

    logic [15:0] imp_exp [N] = '{
        16'h0800, 16'h1000, 16'h0800, 16'h0000,
        16'h1000, 16'h2000, 16'h1000, 16'h0000,
        16'h0800, 16'h1000, 16'h0800, 16'h0000};

    always @(negedge clk) begin
        if (!ready_out) nlow++;
        if (data_valid_out && ncap < 32) begin
            cap_pix[ncap] = pixel_out;
            cap_t[ncap]   = $time;
            sofv[ncap]    = sof_out;
            eolv[ncap]    = eol_out;
            eofv[ncap]    = eof_out;
            ncap++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ncap = 0;
        nlow = 0;
        sofv = '0;
        eolv = '0;
        eofv = '0;
    endtask

    task automatic send(input logic [15:0] p, input logic s);
        pixel_in      = p;
        sof_in        = s;
        data_valid_in = 1'b1;
        @(posedge clk);
        tlast = $time;
        #1;
        data_valid_in = 1'b0;
        sof_in        = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] m);
        clr();
        mode_in = m;
        for (int i = 0; i < N; i++) begin
            send(frm[i], i == 0);
            if (i == 5) t6 = tlast;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, ncap, N);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_px%0d", tag, i), cap_pix[i], expv[i]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {pixel_out, data_valid_out, sof_out, eol_out,
                            eof_out, frame_error_out, ready_out}, 32'h1);
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) begin
            frm[i]  = 16'(i);
            expv[i] = 16'(i);
        end
        run_frame(2'd0);
        check_frame("bypass");
        chk("bypass_latency", 32'(cap_t[0] - t6), 32'd5);
        chk("bypass_sof", sofv, 32'h001);
        chk("bypass_eol", eolv, 32'h888);
        chk("bypass_eof", eofv, 32'h800);
        chk("bypass_flush_cycles", nlow, 32'd5);

        run_frame(2'd3);
        check_frame("reserved");

        for (int i = 0; i < N; i++) begin
            frm[i]  = 16'hFFFF;
            expv[i] = 16'hFFFF;
        end
        run_frame(2'd2);
        check_frame("gauss_ffff");

        for (int i = 0; i < N; i++) begin
            frm[i]  = 16'h8410;
            expv[i] = 16'h8410;
        end
        run_frame(2'd2);
        check_frame("gauss_8410");

        for (int i = 0; i < N; i++) begin
            frm[i]  = 16'h0000;
            expv[i] = imp_exp[i];
        end
        frm[5] = 16'h8000;
        run_frame(2'd2);
        check_frame("gauss_impulse");

        for (int i = 0; i < N; i++) begin
            frm[i]  = 16'h0000;
            expv[i] = 16'h0000;
        end
        frm[1]  = 16'h8000;
        expv[0] = 16'h2000;
        expv[1] = 16'h4000;
        expv[2] = 16'h2000;
        run_frame(2'd1);
        check_frame("horz");
        chk("no_error_yet", frame_error_out, 32'h0);

        clr();
        mode_in = 2'd0;
        for (int i = 0; i < 7; i++) send(16'(i), i == 0);
        for (int i = 0; i < N; i++) send(16'h0100 + 16'(i), i == 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_count", ncap, 32'd14);
        chk("abort_px0", cap_pix[0], 32'h0);
        chk("abort_px1", cap_pix[1], 32'h1);
        for (int i = 0; i < N; i++)
            chk($sformatf("abort_new_px%0d", i), cap_pix[i + 2], 32'h100 + 32'(i));
        chk("abort_sof", sofv, 32'h0005);
        chk("abort_eof", eofv, 32'h2000);
        chk("abort_error", frame_error_out, 32'h1);

        clr();
        for (int i = 0; i < 8; i++) send(16'(i), i == 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid", {pixel_out, data_valid_out, sof_out, eol_out,
                          eof_out, frame_error_out, ready_out}, 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        repeat (6) @(posedge clk);
        #1;
        chk("no_partial", ncap, 32'd0);
        for (int i = 0; i < N; i++) begin
            frm[i]  = 16'h0A00 + 16'(i);
            expv[i] = 16'h0A00 + 16'(i);
        end
        run_frame(2'd0);
        check_frame("after_reset");
        chk("after_reset_eof", eofv, 32'h800);
        chk("after_reset_error", frame_error_out, 32'h0);

        clr();
        mode_in = 2'd0;
        for (int i = 0; i < N; i++) send(frm[i], i == 0);
        pixel_in      = 16'hDEAD;
        data_valid_in = 1'b1;
        @(posedge clk);
        #1 data_valid_in = 1'b0;
        chk("flush_ready_low", ready_out, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check_frame("flush_drop");
        chk("flush_drop_error", frame_error_out, 32'h1);
        chk("flush_ready_back", ready_out, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb565_window_filter.md
# rgb565_window_filter

Parametrised 3x3 smoothing stage for the RGB565 camera stream, successor to the single-line moving-average preprocessor, placed between pixel capture and the skin/face detection logic. It buffers two image lines and applies a selectable kernel (bypass, horizontal [1 2 1], 3x3 Gaussian) with edge replication. It emits exactly IMG_WIDTH×IMG_HEIGHT pixels per frame, with sof/eol/eof markers, and flushes the final line internally.

## Interface
- IMG_WIDTH, 640, pixels per line (≥4)
- IMG_HEIGHT, 480, lines per frame (≥2)
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous and active-low
- pixel_in  in  16  RGB565 {R[15:11],G[10:5],B[4:0]}
- data_valid_in  in  1  pixel_in valid this cycle
- sof_in  in  1  qualifies pixel (0,0); meaningful only with data_valid_in
- mode_in  in  2  0 bypass, 1 horizontal [1 2 1]/4, 2 3x3 Gaussian /16, 3 reserved (= bypass); sampled on sof accept
- ready_out  out  1  1 = input accepted; 0 only in FLUSH
- pixel_out  out  16  filtered RGB565
- data_valid_out  out  1  pixel_out valid
- sof_out / eol_out / eof_out  out  1 each  first pixel / last pixel of line / last pixel of frame, qualified by data_valid_out
- frame_error_out  out  1  sticky protocol error flag

## Operation
- Accept = data_valid_in && ready_out. Valid pixels while not ready are dropped and set frame_error_out.
- States:
  - IDLE: drop non-sof pixels. An accepted sof pixel latches mode, stores as (0,0) → FILL.
  - FILL: first IMG_WIDTH+1 accepts, no output → RUN.
  - RUN: each accept emits one output → FLUSH after the IMG_WIDTH×IMG_HEIGHT-th accept.
  - FLUSH: IMG_WIDTH+1 internal cycles, one output per cycle, ready_out=0 → IDLE.
- Sof accepted in FILL/RUN: set frame_error_out, abandon the current frame (no flush, no eof), treat the pixel as the new (0,0) → FILL.
- Output for centre (x,y) is produced by the accept of raster index n+IMG_WIDTH+1 (n = y·IMG_WIDTH+x), or by the matching FLUSH cycle.
- Window: rows y−1..y+1, cols x−1..x+1, coordinates clamped to [0,IMG_WIDTH−1]×[0,IMG_HEIGHT−1] (edge replication).
- Per channel, the Gaussian is Σw·p with w = 1 2 1 / 2 4 2 / 1 2 1, then (sum+8)>>4. The horizontal filter is (p[x−1]+2p[x]+p[x+1]+2)>>2.
- Accumulators: R/B 9 bits, G 10 bits. A result can never exceed the channel maximum, so no saturation logic is needed.
- Bypass outputs the centre pixel with the same latency and markers as the filtered modes.
- frame_error_out clears only on reset.

## Timing
- Reset values: pixel_out 0, data_valid_out 0, sof/eol/eof_out 0, frame_error_out 0, ready_out 1, state IDLE, counters 0.
- Line-buffer RAM is not reset. Row −1 is never read, because clamping substitutes row 0.
- All outputs are registered. data_valid_out rises 1 cycle after the triggering accept or FLUSH cycle.
- Latency from accept of (0,0) to sof_out is IMG_WIDTH+1 accepts + 1 cycle.
- ready_out is combinational from state. It falls in the cycle after the final accept and rises the cycle after the last FLUSH output.
- Input gaps in RUN produce matching output gaps. FLUSH is never stalled.
- Reset mid-frame aborts immediately. No partial output follows.

## Structure
- Package preproc_pkg holds:
  - mode encodings
  - state enum (IDLE, FILL, RUN, FLUSH)
  - RGB565 field bit ranges
  - kernel rounding constants
- Sub-module line_buffer: IMG_WIDTH×16 RAM, read-before-write at one address per accept. Instantiated twice as a cascade (y−1, y−2).
- Top level contains:
  - x/y counters
  - FSM
  - 3x3 window registers
  - clamp muxes
  - kernel datapath
  - output register

## Test plan
Benches use IMG_WIDTH=4, IMG_HEIGHT=3.
- Reset: hold rst_n low mid-RUN → next cycle all outputs 0, ready_out 1; a new sof frame then completes normally.
- Bypass, inputs 0x0000..0x000B contiguous: first data_valid_out 1 cycle after 6th accept; outputs 0x0000..0x000B in order; sof_out on 1st; eol_out on 4th/8th/12th; eof_out on 12th; last 5 outputs during FLUSH with ready_out=0.
- Gaussian on flat frames 0xFFFF and 0x8410 → every output equals the input value.
- Gaussian, all zeros except (1,1)=0x8000 → (1,1)=0x2000; (0,1),(1,0),(2,1),(1,2)=0x1000; (0,0),(2,0),(0,2),(2,2)=0x0800; all others 0x0000.
- Horizontal, row 0 = {0x0000,0x8000,0x0000,0x0000} → row 0 outputs 0x2000, 0x4000, 0x2000, 0x0000.
- Errors:
  - sof at pixel index 7 → frame_error_out=1, no eof for the aborted frame, following frame correct.
  - valid during FLUSH → pixel dropped, frame_error_out=1.
